// File: rtl/drum_pkg.sv
// Shared constants, stage payload type and position-to-shift helper for the
// DRUM approximate multiplier back end.
package drum_pkg;

    localparam int DRUM_N    = 8;                       // full operand width
    localparam int DRUM_K    = 4;                       // truncated operand width
    localparam int DRUM_LOGN = 3;                       // width of a position code
    localparam int SHAMT_W   = DRUM_LOGN + 1;           // combined shift amount width
    localparam int MAX_SHIFT = 2 * (DRUM_N - DRUM_K);   // largest legal combined shift
    localparam int SEL_W     = MAX_SHIFT + 1;           // one-hot select lines actually used
    localparam int PROD_W    = 2 * DRUM_K;              // truncated product width
    localparam int RES_W     = 2 * DRUM_N;              // full product width
    localparam int DEC_W     = 1 << SHAMT_W;            // raw decoder output width

    // Payload carried from the decode stage to the reconstruct stage.
    typedef struct packed {
        logic [PROD_W-1:0]  prod;
        logic [SHAMT_W-1:0] shamt;
        logic               zero;
    } s1_data_t;

    // Shift contributed by one operand: how far its leading one sits above
    // the top bit of the K-bit window (zero when the operand fits the window).
    function automatic logic [SHAMT_W-1:0] drum_shift(input logic [DRUM_LOGN-1:0] pos);
        logic [SHAMT_W-1:0] pos_ext_s;
        logic [SHAMT_W-1:0] base_s;
        pos_ext_s = {1'b0, pos};
        base_s    = SHAMT_W'(DRUM_K - 1);
        if (pos_ext_s >= base_s) begin
            drum_shift = pos_ext_s - base_s;
        end else begin
            drum_shift = {SHAMT_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with a global enable. The inverse of the DRUM
// front-end position encoder; with en low every output line is zero.
module onehot_decoder #(
    parameter int W = 4
) (
    input  logic [W-1:0]        in,
    input  logic                en,
    output logic [(1<<W)-1:0]   out
);

    // Raise exactly the line whose index equals the binary code when enabled.
    always_comb begin
        out = {(1<<W){1'b0}};
        for (int i = 0; i < (1 << W); i++) begin
            if (en && (in == W'(i))) begin
                out[i] = 1'b1;
            end else begin
                out[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/drum_result_decoder.sv
// DRUM result decoder: turns the two leading-one positions into a combined
// shift, then rebuilds the 2N-bit approximate product from the KxK truncated
// product through a one-hot AND-OR shift mux. Two registered stages with a
// valid/ready handshake on both sides.
import drum_pkg::*;

module drum_result_decoder (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DRUM_LOGN-1:0]  pos_a,
    input  logic [DRUM_LOGN-1:0]  pos_b,
    input  logic                  zero,
    input  logic [PROD_W-1:0]     trunc_prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_W-1:0]      result
);

    logic               s1_valid_r;
    s1_data_t           s1_data_r;
    logic               s2_valid_r;
    logic [RES_W-1:0]   s2_result_r;

    logic               s1_advance_s;
    logic               s2_advance_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               dec_en_s;
    logic [DEC_W-1:0]   onehot_s;
    logic [RES_W-1:0]   prod_ext_s;
    logic [RES_W-1:0]   recon_s;
    logic               unused_onehot_s;

    // Pipeline advance conditions; depend only on registered state and out_ready.
    always_comb begin
        s2_advance_s = !s2_valid_r || out_ready;
        s1_advance_s = !s1_valid_r || s2_advance_s;
    end

    assign in_ready  = s1_advance_s;
    assign out_valid = s2_valid_r;
    assign result    = s2_result_r;

    // Combined shift amount from both operand positions.
    always_comb begin
        shamt_s = drum_shift(pos_a) + drum_shift(pos_b);
    end

    // Decode stage: capture product, shift amount and zero flag on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '{prod: {PROD_W{1'b0}}, shamt: {SHAMT_W{1'b0}}, zero: 1'b0};
        end else if (s1_advance_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r.prod  <= trunc_prod;
                s1_data_r.shamt <= shamt_s;
                s1_data_r.zero  <= zero;
            end
        end
    end

    // Out-of-range shifts and zero operands both leave every select line low,
    // which forces the reconstructed product to 0 without any X.
    always_comb begin
        dec_en_s = (s1_data_r.shamt <= SHAMT_W'(MAX_SHIFT)) && !s1_data_r.zero;
    end

    onehot_decoder #(
        .W (SHAMT_W)
    ) u_onehot (
        .in  (s1_data_r.shamt),
        .en  (dec_en_s),
        .out (onehot_s)
    );

    // Lines above the largest legal shift never select anything.
    assign unused_onehot_s = |onehot_s[DEC_W-1:SEL_W];

    // One-hot AND-OR mux over every legal constant shift of the product.
    always_comb begin
        prod_ext_s = {{(RES_W-PROD_W){1'b0}}, s1_data_r.prod};
        recon_s    = {RES_W{1'b0}};
        for (int i = 0; i < SEL_W; i++) begin
            recon_s = recon_s | ({RES_W{onehot_s[i]}} & (prod_ext_s << i));
        end
    end

    // Reconstruct stage: take stage 1's result when it is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {RES_W{1'b0}};
        end else if (s2_advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_result_r <= recon_s;
            end
        end
    end

endmodule

// File: tb/tb_drum_result_decoder.sv
// Self-checking bench for drum_result_decoder: directed cases plus a long
// randomized valid/ready run against a queue-based arithmetic reference.
module tb_drum_result_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  pos_a;
    logic [2:0]  pos_b;
    logic        zero;
    logic [7:0]  trunc_prod;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int n_tests;
    int n_fail;
    int unsigned exp_q[$];
    int occ;
    bit prev_hold;
    logic [15:0] prev_res;
    int n_done;
    int cyc;
    int unsigned exp_v;

    drum_result_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pos_a      (pos_a),
        .pos_b      (pos_b),
        .zero       (zero),
        .trunc_prod (trunc_prod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: approximate product from the positions, K = 4.
    function automatic int unsigned ref_result(input int pa, input int pb, input bit z, input int tp);
        int sa;
        int sb;
        sa = (pa >= 3) ? pa - 3 : 0;
        sb = (pb >= 3) ? pb - 3 : 0;
        if (z) return 0;
        return tp * (1 << (sa + sb));
    endfunction

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One cycle of handshake accounting; entered and left at a falling edge.
    task automatic cycle_step(input bit iv, input logic [2:0] pa, input logic [2:0] pb,
                              input logic z, input logic [7:0] tp, input bit ordy);
        in_valid   = iv;
        pos_a      = pa;
        pos_b      = pb;
        zero       = z;
        trunc_prod = tp;
        out_ready  = ordy;
        #1;
        check_val("in_ready", in_ready, (occ < 2) || ordy);
        if (prev_hold) begin
            check_val("hold_valid", out_valid, 1);
            check_val("hold_result", result, prev_res);
        end
        if (iv && in_ready) begin
            exp_q.push_back(ref_result(pa, pb, z, tp));
            occ++;
        end
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 1, 0);
            end else begin
                exp_v = exp_q.pop_front();
                check_val("result", result, exp_v);
                n_done++;
            end
            occ--;
        end
        prev_hold = out_valid && !ordy;
        prev_res  = result;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0; occ = 0; prev_hold = 0; prev_res = '0; n_done = 0;
        rst = 1'b1; in_valid = 1'b0; pos_a = '0; pos_b = '0; zero = 1'b0;
        trunc_prod = '0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", result, 0);
        check_val("rst_in_ready", in_ready, 1);

        // Test 1: 39 << 4 = 624, two cycles after the transfer.
        in_valid = 1'b1; pos_a = 3'd7; pos_b = 3'd1; zero = 1'b0; trunc_prod = 8'd39;
        #1; check_val("t1_in_ready", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; #1;
        check_val("t1_lat1_valid", out_valid, 0);
        @(negedge clk); #1;
        check_val("t1_valid", out_valid, 1);
        check_val("t1_result", result, 624);

        // Test 2: zero shift then maximum shift, back to back.
        in_valid = 1'b1; pos_a = 3'd2; pos_b = 3'd2; trunc_prod = 8'd30;
        @(negedge clk);
        pos_a = 3'd7; pos_b = 3'd7; trunc_prod = 8'd225;
        @(negedge clk); in_valid = 1'b0; #1;
        check_val("t2_valid_a", out_valid, 1);
        check_val("t2_result_a", result, 30);
        @(negedge clk); #1;
        check_val("t2_valid_b", out_valid, 1);
        check_val("t2_result_b", result, 57600);

        // Test 3: zero operand flag.
        in_valid = 1'b1; zero = 1'b1; pos_a = 3'd7; pos_b = 3'd7; trunc_prod = 8'd225;
        @(negedge clk); in_valid = 1'b0; zero = 1'b0;
        @(negedge clk); #1;
        check_val("t3_valid", out_valid, 1);
        check_val("t3_result", result, 0);
        @(negedge clk);

        // Test 4: backpressure with four offered transactions.
        exp_q.delete(); occ = 0; prev_hold = 0; n_done = 0;
        for (int i = 0; i < 4; i++) begin
            cycle_step(1'b1, 3'(i + 3), 3'(i), 1'b0, 8'(17 * (i + 1)), 1'b0);
        end
        check_val("t4_accepted", exp_q.size(), 2);
        out_ready = 1'b0; in_valid = 1'b0; #1;
        check_val("t4_in_ready", in_ready, 0);
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
            cycle_step(1'b0, 3'd0, 3'd0, 1'b0, 8'd0, 1'b1);
        end
        check_val("t4_drained", exp_q.size(), 0);
        check_val("t4_outputs", n_done, 2);

        // Test 5: random valid/ready toggling, 1000 transactions.
        n_done = 0; cyc = 0;
        while (n_done < 1000 && cyc < 20000) begin
            cycle_step(($urandom % 4) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       ($urandom % 8) == 0, 8'($urandom_range(0, 255)), ($urandom % 3) != 0);
            cyc++;
        end
        check_val("t5_completed", n_done, 1000);
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
            cycle_step(1'b0, 3'd0, 3'd0, 1'b0, 8'd0, 1'b1);
        end
        check_val("t5_drained", exp_q.size(), 0);

        // Test 6: reset with both stages full.
        cycle_step(1'b0, 3'd0, 3'd0, 1'b0, 8'd0, 1'b1);
        cycle_step(1'b1, 3'd4, 3'd5, 1'b0, 8'd99, 1'b0);
        cycle_step(1'b1, 3'd6, 3'd3, 1'b0, 8'd77, 1'b0);
        cycle_step(1'b0, 3'd0, 3'd0, 1'b0, 8'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_q.delete(); occ = 0; prev_hold = 0;
        #1;
        check_val("t6_out_valid", out_valid, 0);
        check_val("t6_result", result, 0);
        check_val("t6_in_ready", in_ready, 1);
        out_ready = 1'b1;
        in_valid = 1'b1; pos_a = 3'd5; pos_b = 3'd6; zero = 1'b0; trunc_prod = 8'd11;
        @(negedge clk); in_valid = 1'b0; #1;
        check_val("t6_lat1_valid", out_valid, 0);
        @(negedge clk); #1;
        check_val("t6_valid", out_valid, 1);
        check_val("t6_result_new", result, ref_result(5, 6, 1'b0, 11));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
